// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between the core's fetch and data ports.
// One access at a time, round-robin on ties, fixed read latency, one-cycle ack per access.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    // Handshake: a requester raises req and holds it (with stable address/data) until it
    // sees its one-cycle ack; req still high in the IDLE cycle after the ack is a new request.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic       last_dm_q;
    logic       grant_dm_q;
    logic       we_q;
    logic       start;
    logic       take_dm;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        take_dm = 1'b0;
        case (state_q)
            IDLE: begin
                start   = if_req | dm_req;
                // On a tie the port that did not win last time gets the memory.
                take_dm = dm_req & (~if_req | ~last_dm_q);
                if (start) state_d = ISSUE;
            end
            ISSUE:   state_d = we_q ? RESP : WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            last_dm_q  <= 1'b0;
            grant_dm_q <= 1'b0;
            we_q       <= 1'b0;
            if_rdata   <= 32'd0;
            if_ack     <= 1'b0;
            dm_rdata   <= 32'd0;
            dm_ack     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            state_q <= state_d;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        grant_dm_q <= take_dm;
                        last_dm_q  <= take_dm;
                        we_q       <= take_dm & dm_we;
                        mem_en     <= 1'b1;
                        mem_we     <= take_dm & dm_we;
                        mem_addr   <= take_dm ? dm_addr : if_addr;
                        if (take_dm) mem_wdata <= dm_wdata;
                    end
                end
                ISSUE: begin
                    cnt_q <= CNT_INIT;
                    if (we_q) dm_ack <= 1'b1;
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (grant_dm_q) begin
                        dm_rdata <= mem_rdata;
                        dm_ack   <= 1'b1;
                    end else begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

endmodule
